tile_sprite_mapper: RTL

- Pipelined, parametrised successor to the combinational tile colour path.
- Converts the VGA (DrawX, DrawY) stream into RGB through four stages:
  - tile-map lookup,
  - tile-row fetch,
  - sprite overlay with transparency and priority,
  - palette lookup.
- Supports NUM_SPRITES frame-latched sprites (players, cars) drawn over the 16 px tile background.
- Sits between vga_controller and the VGA DAC, and drives external synchronous ROMs.

---
 rtl/tile_sprite_mapper_if.sv | 36 +++
 rtl/tile_sprite_mapper.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tile_sprite_mapper_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_sprite_mapper_if
// Description : External ROM bus of the tile/sprite mapper (map, tile row,
//               sprite row and palette ROMs, all 1-cycle synchronous).
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_sprite_mapper_if #(
    parameter int TILE_BITS     = 4,
    parameter int CODE_BITS     = 8,
    parameter int BANK_BITS     = 3,
    parameter int COLOR_BITS    = 3,
    parameter int SPR_W         = 16,
    parameter int SPR_H         = 32,
    parameter int SPR_CODE_BITS = 4
);
    logic [10:0]                             map_addr;
    logic [CODE_BITS+BANK_BITS-1:0]          map_data;
    logic [CODE_BITS+TILE_BITS-1:0]          tile_addr;
    logic [(COLOR_BITS<<TILE_BITS)-1:0]      tile_data;
    logic [SPR_CODE_BITS+$clog2(SPR_H)-1:0]  spr_addr;
    logic [COLOR_BITS*SPR_W-1:0]             spr_data;
    logic [BANK_BITS+COLOR_BITS-1:0]         pal_addr;
    logic [23:0]                             pal_data;

    modport master (
        output map_addr, tile_addr, spr_addr, pal_addr,
        input  map_data, tile_data, spr_data, pal_data
    );

    modport slave (
        input  map_addr, tile_addr, spr_addr, pal_addr,
        output map_data, tile_data, spr_data, pal_data
    );
endinterface
`default_nettype wire

// File: rtl/tile_sprite_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tile_sprite_mapper
// Description : 4-stage pixel pipeline: tile map, tile row, sprite overlay,
//               palette. Macro TILE_SPRITE_MAPPER_DEPTH_SORT_EN selects
//               bottom-edge depth sorting instead of fixed index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_sprite_mapper #(
    parameter int TILE_BITS     = 4,
    parameter int MAP_COLS      = 40,
    parameter int CODE_BITS     = 8,
    parameter int BANK_BITS     = 3,
    parameter int COLOR_BITS    = 3,
    parameter int NUM_SPRITES   = 4,
    parameter int SPR_W         = 16,
    parameter int SPR_H         = 32,
    parameter int SPR_CODE_BITS = 4
) (
    input  wire                                   Clk,
    input  wire                                   Reset_n,
    input  wire                                   frame_start,
    input  wire                                   Blank,
    input  wire  [9:0]                            DrawX,
    input  wire  [9:0]                            DrawY,
    input  wire  [10*NUM_SPRITES-1:0]             spr_x,
    input  wire  [10*NUM_SPRITES-1:0]             spr_y,
    input  wire  [NUM_SPRITES-1:0]                spr_en,
    input  wire  [SPR_CODE_BITS*NUM_SPRITES-1:0]  spr_code,
    input  wire  [BANK_BITS*NUM_SPRITES-1:0]      spr_bank,
    tile_sprite_mapper_if.master                  rom,
    output logic [7:0]                            Red,
    output logic [7:0]                            Green,
    output logic [7:0]                            Blue
);
    localparam int SPR_DX_BITS = $clog2(SPR_W);
    localparam int SPR_DY_BITS = $clog2(SPR_H);
    localparam int TILE_W      = 1 << TILE_BITS;

    // Frame-latched sprite shadow registers
    logic [10*NUM_SPRITES-1:0]            sx_q, sy_q;
    logic [NUM_SPRITES-1:0]               en_q;
    logic [SPR_CODE_BITS*NUM_SPRITES-1:0] scode_q;
    logic [BANK_BITS*NUM_SPRITES-1:0]     sbank_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            en_q    <= '0;
            scode_q <= '0;
            sbank_q <= '0;
        end else if (frame_start) begin
            sx_q    <= spr_x;
            sy_q    <= spr_y;
            en_q    <= spr_en;
            scode_q <= spr_code;
            sbank_q <= spr_bank;
        end
    end

    // C0: map address and sprite hit/priority
    assign rom.map_addr = 11'(MAP_COLS) * 11'(DrawY >> TILE_BITS) + 11'(DrawX >> TILE_BITS);

    logic                     win_d;
    logic [SPR_DX_BITS-1:0]   dx_d;
    logic [SPR_DY_BITS-1:0]   dy_d;
    logic [SPR_CODE_BITS-1:0] code_d;
    logic [BANK_BITS-1:0]     sbank_d;
    logic [10:0]              sx, sy;
    logic                     hit, take;
`ifdef TILE_SPRITE_MAPPER_DEPTH_SORT_EN
    logic [10:0]              best_bot;
`endif

    always_comb begin
        win_d   = 1'b0;
        dx_d    = '0;
        dy_d    = '0;
        code_d  = '0;
        sbank_d = '0;
        sx      = '0;
        sy      = '0;
        hit     = 1'b0;
        take    = 1'b0;
`ifdef TILE_SPRITE_MAPPER_DEPTH_SORT_EN
        best_bot = '0;
`endif
        for (int i = 0; i < NUM_SPRITES; i++) begin
            // 11-bit compare so a sprite near x=639 cannot wrap to column 0
            sx  = {1'b0, sx_q[10*i +: 10]};
            sy  = {1'b0, sy_q[10*i +: 10]};
            hit = en_q[i]
                  && ({1'b0, DrawX} >= sx) && ({1'b0, DrawX} < sx + 11'(SPR_W))
                  && ({1'b0, DrawY} >= sy) && ({1'b0, DrawY} < sy + 11'(SPR_H));
`ifdef TILE_SPRITE_MAPPER_DEPTH_SORT_EN
            take = hit && (!win_d || (sy + 11'(SPR_H) > best_bot));
`else
            take = hit && !win_d;
`endif
            if (take) begin
                win_d   = 1'b1;
                dx_d    = SPR_DX_BITS'(DrawX - sx_q[10*i +: 10]);
                dy_d    = SPR_DY_BITS'(DrawY - sy_q[10*i +: 10]);
                code_d  = scode_q[SPR_CODE_BITS*i +: SPR_CODE_BITS];
                sbank_d = sbank_q[BANK_BITS*i +: BANK_BITS];
`ifdef TILE_SPRITE_MAPPER_DEPTH_SORT_EN
                best_bot = sy + 11'(SPR_H);
`endif
            end
        end
    end

    logic                     s1_win_q, s1_blank_q;
    logic [SPR_DX_BITS-1:0]   s1_dx_q;
    logic [SPR_DY_BITS-1:0]   s1_dy_q;
    logic [SPR_CODE_BITS-1:0] s1_code_q;
    logic [BANK_BITS-1:0]     s1_sbank_q;
    logic [TILE_BITS-1:0]     s1_xlo_q, s1_ylo_q;

    logic                     s2_win_q, s2_blank_q;
    logic [SPR_DX_BITS-1:0]   s2_dx_q;
    logic [BANK_BITS-1:0]     s2_sbank_q, s2_tbank_q;
    logic [TILE_BITS-1:0]     s2_xlo_q;

    logic                     s3_blank_q;

    // C1: ROM row addresses from the registered C0 data
    assign rom.tile_addr = {rom.map_data[CODE_BITS-1:0], s1_ylo_q};
    assign rom.spr_addr  = {s1_code_q, s1_dy_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_win_q   <= 1'b0;
            s1_blank_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_code_q  <= '0;
            s1_sbank_q <= '0;
            s1_xlo_q   <= '0;
            s1_ylo_q   <= '0;
            s2_win_q   <= 1'b0;
            s2_blank_q <= 1'b0;
            s2_dx_q    <= '0;
            s2_sbank_q <= '0;
            s2_tbank_q <= '0;
            s2_xlo_q   <= '0;
            s3_blank_q <= 1'b0;
        end else begin
            s1_win_q   <= win_d;
            s1_blank_q <= Blank;
            s1_dx_q    <= dx_d;
            s1_dy_q    <= dy_d;
            s1_code_q  <= code_d;
            s1_sbank_q <= sbank_d;
            s1_xlo_q   <= DrawX[TILE_BITS-1:0];
            s1_ylo_q   <= DrawY[TILE_BITS-1:0];
            s2_win_q   <= s1_win_q;
            s2_blank_q <= s1_blank_q;
            s2_dx_q    <= s1_dx_q;
            s2_sbank_q <= s1_sbank_q;
            s2_tbank_q <= rom.map_data[CODE_BITS+BANK_BITS-1:CODE_BITS];
            s2_xlo_q   <= s1_xlo_q;
            s3_blank_q <= s2_blank_q;
        end
    end

    // C2: pixel extraction; sprite index 0 falls through to the map, never
    // to a lower-priority sprite
    logic [COLOR_BITS-1:0] tile_idx, spr_idx;

    assign tile_idx = rom.tile_data[COLOR_BITS*(TILE_W-1-int'(s2_xlo_q)) +: COLOR_BITS];
    assign spr_idx  = rom.spr_data[COLOR_BITS*(SPR_W-1-int'(s2_dx_q)) +: COLOR_BITS];
    assign rom.pal_addr = (s2_win_q && (spr_idx != '0)) ? {s2_sbank_q, spr_idx}
                                                         : {s2_tbank_q, tile_idx};

    // C3: palette output, forced black outside active video
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red   <= 8'd0;
            Green <= 8'd0;
            Blue  <= 8'd0;
        end else if (s3_blank_q) begin
            {Red, Green, Blue} <= rom.pal_data;
        end else begin
            Red   <= 8'd0;
            Green <= 8'd0;
            Blue  <= 8'd0;
        end
    end
endmodule
`default_nettype wire
